// File: rtl/tlul_txn_tracker.sv
// -----------------------------------------------------------------------------
// tlul_txn_tracker
//   Passive TileLink-UL checker and transaction tracker for one A/D channel
//   pair. It keeps one table entry per source ID and checks the legality and
//   stability of A requests. It correlates D responses with the entries and
//   runs a watchdog over outstanding work. It never drives the bus.
//
// Parameters
//   SRC_W      source-ID width (table has 2**SRC_W entries)
//   ADDR_W     address width
//   BEAT_BYTES data-bus bytes (power of 2), equals mask width
//   TIMEOUT    cycles with work outstanding and no D fire before code 12 (>=2)
//
// Ports
//   clock, reset_n                 rising-edge clock, synchronous active-low reset
//   a_valid/a_ready, a_opcode, a_param, a_size, a_source, a_address, a_mask
//                                  observed A channel
//   d_valid/d_ready, d_opcode, d_param, d_size, d_source, d_denied
//                                  observed D channel
//   err_valid                      one-cycle pulse per cycle with an error
//   err_code                       lowest-numbered error of that cycle (0 if none)
//   err_sticky                     set on the first error, held until reset
//   inflight                       number of busy table entries
//
// Error codes
//   1 bad opcode, 2 a_param, 3 a_size, 4 misaligned, 5 mask, 6 source busy,
//   7 A changed while stalled, 8 D on idle source, 9 d_opcode, 10 d_size,
//   11 d_param, 12 watchdog.
//
// Optional build macro
//   TLUL_TXN_TRACKER_ASSERT_EN - adds simulation-only checks. They raise $error
//   on every err_valid and on X in a_valid/d_valid while out of reset. Leave
//   the macro undefined for synthesis. The outputs are the same either way.
// -----------------------------------------------------------------------------

// One tracking entry: busy flag plus the data needed to check the response.
module tlul_txn_entry (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       alloc,
   input  logic       retire,
   input  logic       alloc_exp,
   input  logic [2:0] alloc_size,
   output logic       busy,
   output logic       exp_opcode,
   output logic [2:0] size
);
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         exp_opcode <= 1'b0;
         size       <= 3'd0;
      end else if (alloc) begin
         // alloc wins over retire: same-cycle retire and re-allocate
         busy       <= 1'b1;
         exp_opcode <= alloc_exp;
         size       <= alloc_size;
      end else if (retire) begin
         busy       <= 1'b0;
      end
   end
endmodule

module tlul_txn_tracker #(
   parameter int SRC_W      = 2,
   parameter int ADDR_W     = 30,
   parameter int BEAT_BYTES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  a_valid,
   input  logic                  a_ready,
   input  logic [2:0]            a_opcode,
   input  logic [2:0]            a_param,
   input  logic [2:0]            a_size,
   input  logic [SRC_W-1:0]      a_source,
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [BEAT_BYTES-1:0] a_mask,
   input  logic                  d_valid,
   input  logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [1:0]            d_param,
   input  logic [2:0]            d_size,
   input  logic [SRC_W-1:0]      d_source,
   input  logic                  d_denied,
   output logic                  err_valid,
   output logic [3:0]            err_code,
   output logic                  err_sticky,
   output logic [SRC_W:0]        inflight
);
   localparam int NUM_SRC = 2**SRC_W;
   localparam int LG      = $clog2(BEAT_BYTES);
   localparam int WD_W    = $clog2(TIMEOUT + 1);

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [2:0]            param;
      logic [2:0]            size;
      logic [SRC_W-1:0]      source;
      logic [ADDR_W-1:0]     address;
      logic [BEAT_BYTES-1:0] mask;
   } a_req_t;

   a_req_t                  a_req, hold_req;
   logic                    hold_vld;
   logic                    a_fire, d_fire;
   logic [NUM_SRC-1:0]      busy, alloc, retire, exp_op;
   logic [NUM_SRC-1:0][2:0] ent_size;
   logic [NUM_SRC-1:0]      busy_nxt;
   logic [SRC_W:0]          inflight_nxt;
   logic [WD_W-1:0]         wd;
   logic [15:0]             denied_cnt;

   logic                  op_bad, param_bad, size_bad, addr_bad, mask_bad;
   logic                  a_ok, src_busy, stab_bad;
   logic                  d_busy, d_op_bad, d_size_bad, d_param_bad, wd_expire;
   logic [3:0]            err_code_nxt;
   logic                  err_any;
   logic [BEAT_BYTES-1:0] lanes;
   int                    a_off, a_nbytes;

   assign a_fire = a_valid && a_ready;
   assign d_fire = d_valid && d_ready;
   assign a_req  = '{opcode: a_opcode, param: a_param, size: a_size,
                     source: a_source, address: a_address, mask: a_mask};

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_ent
         tlul_txn_entry u_ent (
            .clock      (clock),
            .reset_n    (reset_n),
            .alloc      (alloc[g]),
            .retire     (retire[g]),
            .alloc_exp  (a_opcode == OP_GET),
            .alloc_size (a_size),
            .busy       (busy[g]),
            .exp_opcode (exp_op[g]),
            .size       (ent_size[g])
         );
      end
   endgenerate

   // ---- A request legality ----
   always_comb begin
      op_bad    = !(a_opcode inside {OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET});
      param_bad = (a_param != 3'd0);
      size_bad  = (a_size > 3'(LG));
      addr_bad  = |(a_address & ((ADDR_W'(1) << a_size) - ADDR_W'(1)));
      // Lanes touched by the access. This is only meaningful when the size
      // and alignment checks pass; the lower codes win otherwise.
      a_off    = 32'(a_address & ADDR_W'(BEAT_BYTES - 1));
      a_nbytes = 1 << a_size;
      lanes    = '0;
      for (int b = 0; b < BEAT_BYTES; b++)
         lanes[b] = (b >= a_off) && (b < a_off + a_nbytes);
      if (a_opcode == OP_PUT_PARTIAL)
         mask_bad = (|(a_mask & ~lanes)) || (a_mask == '0);
      else
         mask_bad = (a_mask != lanes);
      a_ok = !(op_bad || param_bad || size_bad || addr_bad || mask_bad);
   end

   // ---- table control ----
   always_comb begin
      retire = '0;
      alloc  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         retire[i] = d_fire && (d_source == SRC_W'(i)) && busy[i];
         alloc[i]  = a_fire && a_ok && (a_source == SRC_W'(i)) && (!busy[i] || retire[i]);
      end
      src_busy = busy[a_source] && !retire[a_source];
      busy_nxt = (busy & ~retire) | alloc;
      inflight_nxt = '0;
      for (int i = 0; i < NUM_SRC; i++)
         inflight_nxt = inflight_nxt + (SRC_W+1)'(busy_nxt[i]);
   end

   // ---- D response and protocol checks ----
   always_comb begin
      d_busy      = busy[d_source];
      d_op_bad    = (d_opcode != {2'b00, exp_op[d_source]});
      d_size_bad  = (d_size != ent_size[d_source]);
      d_param_bad = (d_param != 2'd0);
      stab_bad    = hold_vld && (!a_valid || (a_req != hold_req));
      wd_expire   = !d_fire && (inflight != '0) && (wd == WD_W'(TIMEOUT - 1));
   end

   // lowest code wins
   always_comb begin
      err_code_nxt = 4'd0;
      if      (a_fire && op_bad)      err_code_nxt = 4'd1;
      else if (a_fire && param_bad)   err_code_nxt = 4'd2;
      else if (a_fire && size_bad)    err_code_nxt = 4'd3;
      else if (a_fire && addr_bad)    err_code_nxt = 4'd4;
      else if (a_fire && mask_bad)    err_code_nxt = 4'd5;
      else if (a_fire && src_busy)    err_code_nxt = 4'd6;
      else if (stab_bad)              err_code_nxt = 4'd7;
      else if (d_fire && !d_busy)     err_code_nxt = 4'd8;
      else if (d_fire && d_op_bad)    err_code_nxt = 4'd9;
      else if (d_fire && d_size_bad)  err_code_nxt = 4'd10;
      else if (d_fire && d_param_bad) err_code_nxt = 4'd11;
      else if (wd_expire)             err_code_nxt = 4'd12;
      err_any = (err_code_nxt != 4'd0);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hold_vld   <= 1'b0;
         hold_req   <= '0;
         inflight   <= '0;
         wd         <= '0;
         denied_cnt <= '0;
         err_valid  <= 1'b0;
         err_code   <= 4'd0;
         err_sticky <= 1'b0;
      end else begin
         // a stalled request must be presented unchanged next cycle
         hold_vld <= a_valid && !a_ready;
         hold_req <= a_req;
         inflight <= inflight_nxt;
         if (d_fire || (inflight == '0) || wd_expire)
            wd <= '0;
         else
            wd <= wd + WD_W'(1);
         // denied responses are legal; the count is a debug observation point
         if (d_fire && d_denied)
            denied_cnt <= denied_cnt + 16'd1;
         err_valid  <= err_any;
         err_code   <= err_code_nxt;
         err_sticky <= err_sticky || err_any;
      end
   end

`ifdef TLUL_TXN_TRACKER_ASSERT_EN
   longint unsigned cyc;
   always @(posedge clock) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
      assert (!err_valid)
         else $error("tlul_txn_tracker: err_code=%0d cycle=%0d", err_code, cyc);
      if (reset_n)
         assert (!$isunknown({a_valid, d_valid}))
            else $error("tlul_txn_tracker: X on a_valid/d_valid cycle=%0d", cyc);
   end
`endif

endmodule
